// File: rtl/field_delta_stats.sv
// field_delta_stats
// Windowed statistics over the deltas of one extracted header field.
// Each accepted sample after the first one in a run produces
// delta = field - prev, an unsigned subtraction that wraps modulo 2^N_BITS.
// After every 2^WINDOW_LOG2 deltas, a snapshot of the window's counts is
// published on the stat_* outputs.
//
// Optional feature: define FIELD_DELTA_STATS_MIN_EN to build the running
// minimum-delta tracker. Without it, stat_min_delta is constant 0.
//
// Ports:
//   sys_clk        rising-edge clock
//   reset_n        asynchronous active-low reset
//   field          field value, sampled when field_valid=1
//   field_valid    one-cycle sample strobe
//   clear          synchronous clear of window state (outputs untouched)
//   stat_valid     one-cycle pulse, new snapshot on stat_*
//   stat_seq       deltas equal to 1 in last window
//   stat_repeat    deltas equal to 0 in last window
//   stat_zero      zero-valued samples that contributed a delta
//   stat_max_delta largest delta in last window
//   stat_min_delta smallest delta in last window (0 when feature absent)
module field_delta_stats #(
  parameter  int unsigned N_BITS      = 16,
  parameter  int unsigned WINDOW_LOG2 = 8,
  localparam int unsigned CNT_W       = WINDOW_LOG2 + 1
) (
  input  logic              sys_clk,
  input  logic              reset_n,
  input  logic [N_BITS-1:0] field,
  input  logic              field_valid,
  input  logic              clear,
  output logic              stat_valid,
  output logic [CNT_W-1:0]  stat_seq,
  output logic [CNT_W-1:0]  stat_repeat,
  output logic [CNT_W-1:0]  stat_zero,
  output logic [N_BITS-1:0] stat_max_delta,
  output logic [N_BITS-1:0] stat_min_delta
);

  typedef enum logic {S_EMPTY = 1'b0, S_RUN = 1'b1} state_t;

  state_t                 state, state_nxt;
  logic [N_BITS-1:0]      prev, prev_nxt;
  logic [WINDOW_LOG2-1:0] win_cnt, win_cnt_nxt;
  logic [CNT_W-1:0]       run_seq, run_seq_nxt;
  logic [CNT_W-1:0]       run_rep, run_rep_nxt;
  logic [CNT_W-1:0]       run_zero, run_zero_nxt;
  logic [N_BITS-1:0]      run_max, run_max_nxt;

  logic [N_BITS-1:0]      delta;
  logic                   accept_delta;
  logic                   win_done;
  logic [CNT_W-1:0]       seq_acc, rep_acc, zero_acc;
  logic [N_BITS-1:0]      max_acc;

  // Per-sample delta and the counts as they stand including this sample
  assign delta        = field - prev;
  assign accept_delta = field_valid && !clear && (state == S_RUN);
  // win_cnt tracks deltas already taken; all-ones means this one closes the window
  assign win_done     = accept_delta && (win_cnt == '1);
  assign seq_acc      = run_seq  + CNT_W'(delta == N_BITS'(1));
  assign rep_acc      = run_rep  + CNT_W'(delta == '0);
  assign zero_acc     = run_zero + CNT_W'(field == '0);
  assign max_acc      = (delta > run_max) ? delta : run_max;

  // State register
  always_ff @(posedge sys_clk or negedge reset_n) begin
    if (!reset_n) state <= S_EMPTY;
    else          state <= state_nxt;
  end

  // Next-state logic: clear has priority over a coincident sample
  always_comb begin
    state_nxt = state;
    if (clear)                                  state_nxt = S_EMPTY;
    else if (field_valid && state == S_EMPTY)   state_nxt = S_RUN;
  end

  // Next values of the window datapath
  always_comb begin
    prev_nxt     = prev;
    win_cnt_nxt  = win_cnt;
    run_seq_nxt  = run_seq;
    run_rep_nxt  = run_rep;
    run_zero_nxt = run_zero;
    run_max_nxt  = run_max;
    if (clear) begin
      win_cnt_nxt  = '0;
      run_seq_nxt  = '0;
      run_rep_nxt  = '0;
      run_zero_nxt = '0;
      run_max_nxt  = '0;
    end else if (field_valid) begin
      prev_nxt = field;
      if (win_done) begin
        win_cnt_nxt  = '0;
        run_seq_nxt  = '0;
        run_rep_nxt  = '0;
        run_zero_nxt = '0;
        run_max_nxt  = '0;
      end else if (accept_delta) begin
        win_cnt_nxt  = win_cnt + WINDOW_LOG2'(1);
        run_seq_nxt  = seq_acc;
        run_rep_nxt  = rep_acc;
        run_zero_nxt = zero_acc;
        run_max_nxt  = max_acc;
      end
    end
  end

  // Window datapath registers
  always_ff @(posedge sys_clk or negedge reset_n) begin
    if (!reset_n) begin
      prev     <= '0;
      win_cnt  <= '0;
      run_seq  <= '0;
      run_rep  <= '0;
      run_zero <= '0;
      run_max  <= '0;
    end else begin
      prev     <= prev_nxt;
      win_cnt  <= win_cnt_nxt;
      run_seq  <= run_seq_nxt;
      run_rep  <= run_rep_nxt;
      run_zero <= run_zero_nxt;
      run_max  <= run_max_nxt;
    end
  end

  // Snapshot registers, loaded with counts that include the closing delta
  always_ff @(posedge sys_clk or negedge reset_n) begin
    if (!reset_n) begin
      stat_valid     <= 1'b0;
      stat_seq       <= '0;
      stat_repeat    <= '0;
      stat_zero      <= '0;
      stat_max_delta <= '0;
    end else begin
      stat_valid <= win_done;
      if (win_done) begin
        stat_seq       <= seq_acc;
        stat_repeat    <= rep_acc;
        stat_zero      <= zero_acc;
        stat_max_delta <= max_acc;
      end
    end
  end

`ifdef FIELD_DELTA_STATS_MIN_EN
  logic [N_BITS-1:0] run_min;
  logic [N_BITS-1:0] min_acc;

  assign min_acc = (delta < run_min) ? delta : run_min;

  // Running minimum, seeded to all-ones at every window start
  always_ff @(posedge sys_clk or negedge reset_n) begin
    if (!reset_n) begin
      run_min        <= '1;
      stat_min_delta <= '0;
    end else begin
      if (clear || win_done) run_min <= '1;
      else if (accept_delta) run_min <= min_acc;
      if (win_done) stat_min_delta <= min_acc;
    end
  end
`else
  assign stat_min_delta = '0;
`endif

endmodule

// File: tb/tb_field_delta_stats.sv
// Directed bench for field_delta_stats with a 4-delta window, 16-bit field.
module tb_field_delta_stats;

  localparam int unsigned N_BITS      = 16;
  localparam int unsigned WINDOW_LOG2 = 2;
  localparam int unsigned CNT_W       = WINDOW_LOG2 + 1;
`ifdef FIELD_DELTA_STATS_MIN_EN
  localparam bit MIN_EN = 1'b1;
`else
  localparam bit MIN_EN = 1'b0;
`endif

  logic              sys_clk = 1'b0;
  logic              reset_n;
  logic [N_BITS-1:0] field;
  logic              field_valid;
  logic              clear;
  logic              stat_valid;
  logic [CNT_W-1:0]  stat_seq;
  logic [CNT_W-1:0]  stat_repeat;
  logic [CNT_W-1:0]  stat_zero;
  logic [N_BITS-1:0] stat_max_delta;
  logic [N_BITS-1:0] stat_min_delta;

  int checks = 0;
  int errors = 0;
  int snaps  = 0;
  int snaps0;

  field_delta_stats #(.N_BITS(N_BITS), .WINDOW_LOG2(WINDOW_LOG2)) dut (
    .sys_clk       (sys_clk),
    .reset_n       (reset_n),
    .field         (field),
    .field_valid   (field_valid),
    .clear         (clear),
    .stat_valid    (stat_valid),
    .stat_seq      (stat_seq),
    .stat_repeat   (stat_repeat),
    .stat_zero     (stat_zero),
    .stat_max_delta(stat_max_delta),
    .stat_min_delta(stat_min_delta)
  );

  always #5 sys_clk = ~sys_clk;

  // Count snapshot pulses, sampled just after each rising edge
  always @(posedge sys_clk) begin
    #1;
    if (stat_valid) snaps++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    if (obs !== exp_v) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp_v);
    end
  endtask

  // Present one sample; check the pulse just after the accepting edge
  task automatic send(input logic [N_BITS-1:0] v, input bit exp_pulse);
    @(negedge sys_clk);
    field       = v;
    field_valid = 1'b1;
    @(posedge sys_clk);
    #1;
    check("stat_valid", 32'(stat_valid), 32'(exp_pulse));
  endtask

  task automatic idle();
    @(negedge sys_clk);
    field_valid = 1'b0;
    @(posedge sys_clk);
  endtask

  task automatic send_g(input logic [N_BITS-1:0] v, input bit exp_pulse);
    send(v, exp_pulse);
    idle();
  endtask

  task automatic do_clear();
    @(negedge sys_clk);
    clear       = 1'b1;
    field_valid = 1'b0;
    @(posedge sys_clk);
    #1;
    clear = 1'b0;
  endtask

  task automatic chk_stats(input string tag, input int s, input int r, input int z,
                           input int mx, input int mn);
    check({tag, ".seq"},    32'(stat_seq),       32'(s));
    check({tag, ".repeat"}, 32'(stat_repeat),    32'(r));
    check({tag, ".zero"},   32'(stat_zero),      32'(z));
    check({tag, ".max"},    32'(stat_max_delta), 32'(mx));
    check({tag, ".min"},    32'(stat_min_delta), MIN_EN ? 32'(mn) : 32'd0);
  endtask

  task automatic chk_all_zero(input string tag);
    check({tag, ".valid"}, 32'(stat_valid), 32'd0);
    chk_stats(tag, 0, 0, 0, 0, 0);
  endtask

  logic [N_BITS-1:0] wrap_v [5] = '{16'hFFFE, 16'hFFFF, 16'h0000, 16'h0001, 16'h0002};
  logic [N_BITS-1:0] rep_v  [9] = '{16'd5, 16'd5, 16'd5, 16'd9, 16'd9, 16'd9, 16'd10, 16'd11, 16'd12};
  logic [N_BITS-1:0] rst_v  [5] = '{16'hFFFE, 16'hFFFF, 16'h0000, 16'h0000, 16'h0003};
  logic [N_BITS-1:0] mac_v  [5] = '{16'h10, 16'h20, 16'h30, 16'h31, 16'h41};

  initial begin
    reset_n     = 1'b0;
    field       = '0;
    field_valid = 1'b0;
    clear       = 1'b0;
    #12;
    chk_all_zero("reset");
    @(negedge sys_clk);
    reset_n = 1'b1;

    // Sequential IDs with 1-cycle gaps
    for (int i = 0; i < 5; i++) send_g(16'h1000 + N_BITS'(i), i == 4);
    chk_stats("seq", 4, 0, 0, 1, 1);

    // Wrap-around through zero
    do_clear();
    for (int i = 0; i < 5; i++) send_g(wrap_v[i], i == 4);
    chk_stats("wrap", 4, 0, 1, 1, 1);

    // Repeats, back-to-back through the snapshot cycle
    do_clear();
    for (int i = 0; i < 9; i++) begin
      send(rep_v[i], i == 4 || i == 8);
      if (i == 4) chk_stats("rep1", 0, 3, 0, 4, 0);
      if (i == 8) chk_stats("rep2", 3, 1, 0, 1, 0);
    end
    idle();

    // Clear colliding with a sample
    do_clear();
    snaps0 = snaps;
    for (int i = 0; i < 3; i++) send_g(16'h100 * N_BITS'(i + 1), 1'b0);
    @(negedge sys_clk);
    clear       = 1'b1;
    field       = 16'h7;
    field_valid = 1'b1;
    @(posedge sys_clk);
    #1;
    check("clr.valid", 32'(stat_valid), 32'd0);
    clear       = 1'b0;
    field_valid = 1'b0;
    for (int i = 1; i <= 4; i++) send_g(N_BITS'(i), 1'b0);
    chk_stats("clr.hold", 3, 1, 0, 1, 0);
    send_g(16'd5, 1'b1);
    chk_stats("clr", 4, 0, 0, 1, 1);
    idle();
    check("clr.snaps", 32'(snaps - snaps0), 32'd1);

    // Asynchronous reset mid-window
    for (int i = 0; i < 3; i++) send_g(16'h50 + N_BITS'(i), 1'b0);
    @(posedge sys_clk);
    #3;
    reset_n = 1'b0;
    #1;
    chk_all_zero("rst");
    @(negedge sys_clk);
    reset_n = 1'b1;
    for (int i = 0; i < 5; i++) send_g(rst_v[i], i == 4);
    chk_stats("rst.run", 2, 1, 2, 3, 0);

    // Minimum tracking
    do_clear();
    for (int i = 0; i < 5; i++) send_g(mac_v[i], i == 4);
    chk_stats("min", 1, 0, 0, 16'h10, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
